// File: rtl/ysyx_22050078_ifu_prefetch.sv
// Instruction fetch unit: issues pipelined reads from the fetch PC, queues the returned
// instructions in a prefetch FIFO and discards responses made stale by a redirect.
module ysyx_22050078_ifu_prefetch #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(64'h8000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst_out,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_fault
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = CNT_W + 2;
  localparam int LANES  = DATA_WIDTH / INST_WIDTH;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [ADDR_WIDTH-1:0] fetch_pc_reg;
  logic [PTR_W-1:0]      fifo_wr_ptr_reg, fifo_rd_ptr_reg;
  logic [PTR_W-1:0]      pcq_wr_ptr_reg, pcq_rd_ptr_reg;
  logic [CNT_W-1:0]      fifo_count_reg, fifo_count_next;
  logic [CNT_W-1:0]      inflight_reg, inflight_next;
  logic [CNT_W-1:0]      drop_cnt_reg, drop_cnt_next;
  logic [CNT_W-1:0]      pending_old;

  logic [ADDR_WIDTH-1:0] fifo_pc_mem    [DEPTH];
  logic [INST_WIDTH-1:0] fifo_inst_mem  [DEPTH];
  logic                  fifo_fault_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pcq_mem        [DEPTH];

  logic [SUM_W-1:0]      occupancy;
  logic                  fifo_nonempty;
  logic                  req_fire, inst_fire, rsp_drop, rsp_take;
  logic [ADDR_WIDTH-1:0] rsp_pc;
  logic [LANE_W-1:0]     rsp_lane;
  logic [INST_WIDTH-1:0] lane_data [LANES];
  logic [INST_WIDTH-1:0] rsp_inst;

  // Queued, in-flight and to-be-dropped slots together never exceed DEPTH, so the FIFO cannot overflow.
  assign occupancy     = SUM_W'(fifo_count_reg) + SUM_W'(inflight_reg) + SUM_W'(drop_cnt_reg);
  assign fifo_nonempty = (fifo_count_reg != '0);
  assign req_valid     = ~rst & fetch_en & ~redirect_valid & (occupancy < SUM_W'(DEPTH));
  assign req_addr      = fetch_pc_reg;
  assign req_fire      = req_valid & req_ready;
  assign inst_valid    = fifo_nonempty & ~redirect_valid;
  assign inst_fire     = inst_valid & inst_ready;

  assign rsp_drop = rsp_valid & ~redirect_valid & (drop_cnt_reg != '0);
  assign rsp_take = rsp_valid & ~redirect_valid & (drop_cnt_reg == '0) & (inflight_reg != '0);
  assign rsp_pc   = pcq_mem[pcq_rd_ptr_reg];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_data[gi] = rsp_data[gi*INST_WIDTH +: INST_WIDTH];
    end
    if (LANES > 1) begin : g_lane_sel
      assign rsp_lane = rsp_pc[$clog2(DATA_WIDTH/8)-1:2];
    end else begin : g_lane_single
      assign rsp_lane = '0;
    end
  endgenerate
  assign rsp_inst = lane_data[rsp_lane];

  assign inst_out   = fifo_nonempty ? fifo_inst_mem[fifo_rd_ptr_reg]  : '0;
  assign inst_pc    = fifo_nonempty ? fifo_pc_mem[fifo_rd_ptr_reg]    : '0;
  assign inst_fault = fifo_nonempty ? fifo_fault_mem[fifo_rd_ptr_reg] : 1'b0;

  always_comb begin
    fifo_count_next = fifo_count_reg;
    inflight_next   = inflight_reg;
    drop_cnt_next   = drop_cnt_reg;
    pending_old     = drop_cnt_reg + inflight_reg;
    if (redirect_valid) begin
      // Everything still owed by memory belongs to the old stream; a response arriving now is one of them.
      fifo_count_next = '0;
      inflight_next   = '0;
      if (rsp_valid && pending_old != '0) begin
        pending_old = pending_old - 1'b1;
      end
      drop_cnt_next = pending_old;
    end else begin
      fifo_count_next = fifo_count_reg + CNT_W'(rsp_take) - CNT_W'(inst_fire);
      inflight_next   = inflight_reg + CNT_W'(req_fire) - CNT_W'(rsp_take);
      if (rsp_drop) begin
        drop_cnt_next = drop_cnt_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      fifo_wr_ptr_reg <= '0;
      fifo_rd_ptr_reg <= '0;
      pcq_wr_ptr_reg  <= '0;
      pcq_rd_ptr_reg  <= '0;
      fifo_count_reg  <= '0;
      inflight_reg    <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      fifo_count_reg <= fifo_count_next;
      inflight_reg   <= inflight_next;
      drop_cnt_reg   <= drop_cnt_next;
      if (redirect_valid) begin
        fetch_pc_reg    <= redirect_pc & ~ADDR_WIDTH'(3);
        fifo_wr_ptr_reg <= '0;
        fifo_rd_ptr_reg <= '0;
        pcq_wr_ptr_reg  <= '0;
        pcq_rd_ptr_reg  <= '0;
      end else begin
        if (req_fire) begin
          fetch_pc_reg   <= fetch_pc_reg + ADDR_WIDTH'(4);
          pcq_wr_ptr_reg <= pcq_wr_ptr_reg + 1'b1;
        end
        if (rsp_take) begin
          pcq_rd_ptr_reg  <= pcq_rd_ptr_reg + 1'b1;
          fifo_wr_ptr_reg <= fifo_wr_ptr_reg + 1'b1;
        end
        if (inst_fire) begin
          fifo_rd_ptr_reg <= fifo_rd_ptr_reg + 1'b1;
        end
      end
    end
  end

  // Storage arrays carry no reset; the counters above decide which entries are live.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_mem[pcq_wr_ptr_reg] <= fetch_pc_reg;
    end
    if (rsp_take) begin
      fifo_pc_mem[fifo_wr_ptr_reg]    <= rsp_pc;
      fifo_inst_mem[fifo_wr_ptr_reg]  <= rsp_inst;
      fifo_fault_mem[fifo_wr_ptr_reg] <= rsp_err;
    end
  end
endmodule

// File: tb/tb_ysyx_22050078_ifu_prefetch.sv
// Bench for the prefetching IFU: in-order memory model with optional hold, plus a
// scoreboard of expected {pc, inst, fault} pushed on every accepted request.
module tb_ysyx_22050078_ifu_prefetch;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [63:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [63:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [63:0] inst_pc;
  logic        inst_fault;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        fault;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] mem_q[$];
  logic        mem_hold = 1'b0;
  logic        mem_hold_s;
  logic [63:0] err_addr = '1;
  int          req_cnt = 0;

  always #5 clk = ~clk;

  ysyx_22050078_ifu_prefetch dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
    .inst_pc(inst_pc), .inst_fault(inst_fault)
  );

  // Distinct value per 4-byte address, so a wrong lane select shows up as a data mismatch.
  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_5A5A;
  endfunction

  // Monitor + request capture, both sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && inst_valid && inst_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h inst=%h fault=%b, required no output", inst_pc, inst_out, inst_fault);
      end else begin
        e = exp_q.pop_front();
        if ({inst_pc, inst_out, inst_fault} !== {e.pc, e.inst, e.fault}) begin
          n_fail++;
          $display("FAIL sb_inst: got pc=%h inst=%h fault=%b, required pc=%h inst=%h fault=%b",
                   inst_pc, inst_out, inst_fault, e.pc, e.inst, e.fault);
        end else begin
          $display("inst pc=%h inst=%h fault=%b", inst_pc, inst_out, inst_fault);
        end
      end
    end
    if (!rst && req_valid && req_ready) begin
      mem_q.push_back(req_addr);
      e.pc    = req_addr;
      e.inst  = word_of(req_addr);
      e.fault = (req_addr == err_addr);
      exp_q.push_back(e);
      req_cnt++;
    end
  end

  // In-order memory: one response per cycle, one cycle after acceptance unless held.
  always @(posedge clk) begin
    logic [63:0] a;
    mem_hold_s = mem_hold;
    #1;
    if (rst) begin
      mem_q.delete();
      rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    end else if (!mem_hold_s && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      rsp_valid = 1'b1;
      rsp_data  = {word_of({a[63:3], 3'b100}), word_of({a[63:3], 3'b000})};
      rsp_err   = (a == err_addr);
    end else begin
      rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; req_ready = 1'b1; inst_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b, required 0", req_valid); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b, required 0", inst_valid); end
    n_cmp++; if (inst_out !== 32'h0) begin n_fail++; $display("FAIL reset_inst_out: got %h, required 0", inst_out); end
    n_cmp++; if (inst_pc !== 64'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h, required 0", inst_pc); end
    n_cmp++; if (inst_fault !== 1'b0) begin n_fail++; $display("FAIL reset_inst_fault: got %b, required 0", inst_fault); end
    n_cmp++; if (req_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h, required %h", req_addr, RESET_PC); end
    @(posedge clk); #1;
    fetch_en = 1'b0; rst = 1'b0;
    tick(1);
  endtask

  task automatic test_sequential();
    logic [63:0] exp_addr = RESET_PC;
    int base = req_cnt;
    inst_ready = 1'b1; req_ready = 1'b1; fetch_en = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (req_valid && req_ready) begin
        n_cmp++;
        if (req_addr !== exp_addr) begin n_fail++; $display("FAIL seq_req_addr: got %h, required %h", req_addr, exp_addr); end
        exp_addr += 64'd4;
      end
      @(posedge clk); #1;
    end
    fetch_en = 1'b0;
    tick(6);
    n_cmp++; if (req_cnt - base != 12) begin n_fail++; $display("FAIL seq_throughput: got %0d requests, required 12", req_cnt - base); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL seq_drain: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int base = req_cnt;
    inst_ready = 1'b0; fetch_en = 1'b1;
    tick(10);
    @(negedge clk);
    n_cmp++; if (req_cnt - base != 4) begin n_fail++; $display("FAIL bp_fill_reqs: got %0d, required 4", req_cnt - base); end
    n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b, required 0", req_valid); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL bp_inst_valid: got %b, required 1", inst_valid); end
    @(posedge clk); #1;
    base = req_cnt;
    inst_ready = 1'b1;
    tick(1);
    inst_ready = 1'b0;
    tick(8);
    n_cmp++; if (req_cnt - base != 1) begin n_fail++; $display("FAIL bp_refill_reqs: got %0d, required 1", req_cnt - base); end
    n_cmp++; if (exp_q.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d, required 4", exp_q.size()); end
    inst_ready = 1'b1; fetch_en = 1'b0;
    tick(8);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_redirect();
    int base = req_cnt;
    int guard = 0;
    mem_hold = 1'b1; inst_ready = 1'b1; fetch_en = 1'b1;
    while (req_cnt - base < 3 && guard < 20) begin @(posedge clk); #1; guard++; end
    n_cmp++; if (req_cnt - base != 3) begin n_fail++; $display("FAIL redir_setup: got %0d requests, required 3", req_cnt - base); end
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1002; exp_q.delete();
    tick(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL redir_req_valid: got %b, required 1", req_valid); end
    n_cmp++; if (req_addr !== 64'h8000_1000) begin n_fail++; $display("FAIL redir_req_addr: got %h, required 80001000", req_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got inst_valid=%b, required 0", inst_valid); end
    @(posedge clk); #1;
    mem_hold = 1'b0;
    guard = 0;
    while (guard < 30) begin @(negedge clk); if (inst_valid) break; guard++; end
    n_cmp++; if (!inst_valid || inst_pc !== 64'h8000_1000) begin n_fail++; $display("FAIL redir_first_pc: got valid=%b pc=%h, required pc=80001000", inst_valid, inst_pc); end
    @(posedge clk); #1;
    fetch_en = 1'b0;
    tick(12);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL redir_drain: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_redirect_with_rsp();
    int base = req_cnt;
    int guard = 0;
    mem_hold = 1'b1; inst_ready = 1'b1; fetch_en = 1'b1;
    while (req_cnt - base < 2 && guard < 20) begin @(posedge clk); #1; guard++; end
    fetch_en = 1'b0; mem_hold = 1'b0;
    n_cmp++; if (req_cnt - base != 2) begin n_fail++; $display("FAIL rr_setup: got %0d requests, required 2", req_cnt - base); end
    tick(1);
    redirect_valid = 1'b1; redirect_pc = 64'h8000_2000; exp_q.delete();
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rr_inst_valid_redir: got %b, required 0", inst_valid); end
    n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rr_req_valid_redir: got %b, required 0", req_valid); end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rr_stale_dropped: cycle %0d got inst_valid=%b pc=%h, required 0", c, inst_valid, inst_pc); end
      @(posedge clk); #1;
    end
    fetch_en = 1'b1;
    guard = 0;
    while (guard < 30) begin @(negedge clk); if (inst_valid) break; guard++; end
    n_cmp++; if (!inst_valid || inst_pc !== 64'h8000_2000) begin n_fail++; $display("FAIL rr_first_pc: got valid=%b pc=%h, required pc=80002000", inst_valid, inst_pc); end
    @(posedge clk); #1;
    fetch_en = 1'b0;
    tick(8);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_drain: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_fault();
    int faults = 0;
    logic [63:0] fault_pc = '0;
    err_addr = 64'h8000_0008;
    redirect_valid = 1'b1; redirect_pc = RESET_PC; exp_q.delete();
    tick(1);
    redirect_valid = 1'b0; inst_ready = 1'b1; fetch_en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (inst_valid && inst_ready && inst_fault) begin faults++; fault_pc = inst_pc; end
      @(posedge clk); #1;
      if (c == 5) fetch_en = 1'b0;
    end
    n_cmp++; if (faults != 1 || fault_pc !== 64'h8000_0008) begin n_fail++; $display("FAIL fault_single: got %0d faults last pc=%h, required 1 at 80000008", faults, fault_pc); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL fault_drain: got %0d outstanding, required 0", exp_q.size()); end
    err_addr = '1;
  endtask

  task automatic test_reset_mid();
    int base = req_cnt;
    int guard = 0;
    inst_ready = 1'b0; fetch_en = 1'b1;
    while (req_cnt - base < 2 && guard < 20) begin @(posedge clk); #1; guard++; end
    fetch_en = 1'b0;
    tick(3);
    @(negedge clk);
    n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_prefill: got inst_valid=%b, required 1", inst_valid); end
    #2;
    rst = 1'b1; fetch_en = 1'b1; mem_q.delete(); exp_q.delete();
    #1;
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_inst_valid: got %b, required 0", inst_valid); end
    n_cmp++; if (inst_out !== 32'h0) begin n_fail++; $display("FAIL rstmid_inst_out: got %h, required 0", inst_out); end
    n_cmp++; if (inst_pc !== 64'h0) begin n_fail++; $display("FAIL rstmid_inst_pc: got %h, required 0", inst_pc); end
    n_cmp++; if (inst_fault !== 1'b0) begin n_fail++; $display("FAIL rstmid_inst_fault: got %b, required 0", inst_fault); end
    n_cmp++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_req_valid: got %b, required 0", req_valid); end
    n_cmp++; if (req_addr !== RESET_PC) begin n_fail++; $display("FAIL rstmid_req_addr: got %h, required %h", req_addr, RESET_PC); end
    @(posedge clk); #1;
    fetch_en = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    inst_ready = 1'b1; fetch_en = 1'b1;
    guard = 0;
    while (guard < 30) begin @(negedge clk); if (inst_valid) break; guard++; end
    n_cmp++; if (!inst_valid || inst_pc !== RESET_PC) begin n_fail++; $display("FAIL rstmid_restart_pc: got valid=%b pc=%h, required pc=%h", inst_valid, inst_pc, RESET_PC); end
    @(posedge clk); #1;
    fetch_en = 1'b0;
    tick(8);
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rstmid_drain: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_with_rsp();
    test_fault();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22050078_ifu_prefetch.md
Name: ysyx_22050078_ifu_prefetch

Overview:
Parametrised next-generation instruction fetch unit: owns the fetch PC and issues pipelined read requests over a valid/ready memory port. It buffers returned instructions in a prefetch FIFO and delivers {pc, inst, fault} to the IDU over a valid/ready handshake. Redirects from the PCU (branch/jump/trap) flush the queue and discard stale in-flight responses.

Parameters:
ADDR_WIDTH, 64, fetch PC / memory address width
INST_WIDTH, 32, instruction width (fixed 4-byte step)
DATA_WIDTH, 64, memory response width; multiple of INST_WIDTH
DEPTH, 4, prefetch FIFO depth and outstanding-request budget; power of 2, ≥2
RESET_PC, 64'h8000_0000, fetch PC after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
fetch_en  in  1  1 = allowed to issue new requests
redirect_valid  in  1  PCU redirect strobe (single cycle)
redirect_pc  in  ADDR_WIDTH  new fetch PC; bits [1:0] ignored (treated as 0)
req_valid  out  1  memory read request valid
req_ready  in  1  memory accepts request
req_addr  out  ADDR_WIDTH  request address (= fetch PC)
rsp_valid  in  1  memory response valid; in order; no backpressure
rsp_data  in  DATA_WIDTH  aligned DATA_WIDTH word containing the requested address
rsp_err  in  1  access fault for this response
inst_valid  out  1  FIFO head valid to IDU
inst_ready  in  1  IDU accepts head
inst_out  out  INST_WIDTH  head instruction
inst_pc  out  ADDR_WIDTH  head PC
inst_fault  out  1  head carries access fault

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, FIFO empty, inflight=0, drop_cnt=0, pc queue empty. Outputs: req_valid=0, inst_valid=0, inst_out=0, inst_pc=0, inst_fault=0, req_addr=RESET_PC.
- State: fetch_pc; inst FIFO (count 0..DEPTH); pc queue of accepted, non-dropped requests (inflight 0..DEPTH); drop_cnt 0..DEPTH.
- req_valid = fetch_en & !redirect_valid & (count + inflight + drop_cnt < DEPTH). Invariant: sum ≤ DEPTH always → FIFO never overflows.
- req_addr = fetch_pc; on req_valid&req_ready: push fetch_pc to pc queue, fetch_pc += 4 (wraps mod 2^ADDR_WIDTH), inflight++.
- Response: if drop_cnt>0 → discard, drop_cnt--. Else pop pc queue (inflight--), lane = pc[log2(DATA_WIDTH/8)-1:2], push {pc, rsp_data[lane*INST_WIDTH +: INST_WIDTH], rsp_err} into FIFO. Response-to-inst_valid latency: 1 cycle (registered FIFO write, visible next cycle).
- rsp_valid with inflight=0 and drop_cnt=0: protocol error; ignore response, no state change.
- inst_valid = (count≠0) & !redirect_valid. Pop on inst_valid&inst_ready. inst_out/inst_pc/inst_fault show FIFO head; 0 when empty.
- Same-cycle push and pop on FIFO: both occur, count unchanged; when empty, pushed entry is not bypassed (appears next cycle).
- Redirect (redirect_valid=1), priority over everything:
  - next cycle: fetch_pc=redirect_pc & ~3; FIFO emptied; pc queue emptied; inflight=0.
  - drop_cnt_next = drop_cnt + inflight − (rsp_valid ? 1 : 0); the same-cycle response is discarded (it belongs to the old stream).
  - No request issued and no IDU handshake in the redirect cycle.
  - Back-to-back redirects: last one wins; drop accounting accumulates per rule above.
- Faulted entries are delivered like normal ones; the fetch stream continues, and the IDU/PCU decides whether to trap via redirect.
- Reset asserted mid-operation: all state cleared immediately; responses in flight at reset are the memory model's responsibility (bench resets both).

Test Plan:
- Reset then fetch_en=1, req_ready=1, 1-cycle memory: req_addr 8000_0000, _04, _08…; inst_pc sequence matches; lane select picks rsp_data[31:0] for …00 and [63:32] for …04.
- inst_ready=0, memory always ready: exactly DEPTH=4 requests issued, then req_valid=0; count=4; one pop → exactly one new request.
- 3 requests in flight, redirect_pc=8000_1002: next req_addr=8000_1000; 3 old responses discarded (drop_cnt 3→0); first inst_pc=8000_1000.
- Redirect in the same cycle as a response with inflight=2: drop_cnt=1, FIFO empty, no inst_valid that cycle.
- rsp_err=1 on request for 8000_0008: inst_fault=1 only on that entry; neighbours fault=0.
- Assert rst while the FIFO holds 2 entries: outputs return to reset values combinationally; req_addr=RESET_PC.
